// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU front-end arbiter.
package fpu_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned FFLAGS_W = 5;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fpu_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic [2:0]      rm;
  } fpu_op_t;

endpackage

// File: rtl/fpu_rr_grant.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the requester not granted last.
module fpu_rr_grant
  import fpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req[0] && (!req[1] || last_grant)) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Arbitrates two requesters onto a single FPU: issue, wait for completion or timeout, pulse the result back.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR      = NOP_INSTR_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                req0_valid_i,
  output logic                req0_ready_o,
  input  logic [31:0]         req0_instr_i,
  input  logic [XLEN-1:0]     req0_rs1_i,
  input  logic [XLEN-1:0]     req0_rs2_i,
  input  logic [XLEN-1:0]     req0_rs3_i,
  input  logic [2:0]          req0_rm_i,
  input  logic                req1_valid_i,
  output logic                req1_ready_o,
  input  logic [31:0]         req1_instr_i,
  input  logic [XLEN-1:0]     req1_rs1_i,
  input  logic [XLEN-1:0]     req1_rs2_i,
  input  logic [XLEN-1:0]     req1_rs3_i,
  input  logic [2:0]          req1_rm_i,
  output logic                rsp0_valid_o,
  output logic [XLEN-1:0]     rsp0_data_o,
  output logic [FFLAGS_W-1:0] rsp0_fflags_o,
  output logic                rsp0_err_o,
  output logic                rsp1_valid_o,
  output logic [XLEN-1:0]     rsp1_data_o,
  output logic [FFLAGS_W-1:0] rsp1_fflags_o,
  output logic                rsp1_err_o,
  output logic                fpu_enable_o,
  output logic [31:0]         fpu_instr_o,
  output logic [XLEN-1:0]     fpu_rs1_o,
  output logic [XLEN-1:0]     fpu_rs2_o,
  output logic [XLEN-1:0]     fpu_rs3_o,
  output logic [2:0]          fpu_rm_o,
  input  logic                fpu_busy_i,
  input  logic [XLEN-1:0]     fpu_out_i,
  input  logic [FFLAGS_W-1:0] fpu_fflags_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  fpu_state_e          state_q, state_d;
  fpu_op_t             op_q, op_sel;
  fpu_op_t             req0_op, req1_op;
  logic                owner_q;
  logic                last_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [XLEN-1:0]     data_q;
  logic [FFLAGS_W-1:0] fflags_q;
  logic                err_q;
  logic [1:0]          grant;
  logic                accept, done, timeout, active, in_flight;

  assign req0_op = '{instr: req0_instr_i, rs1: req0_rs1_i, rs2: req0_rs2_i,
                     rs3: req0_rs3_i, rm: req0_rm_i};
  assign req1_op = '{instr: req1_instr_i, rs1: req1_rs1_i, rs2: req1_rs2_i,
                     rs3: req1_rs3_i, rm: req1_rm_i};
  assign op_sel  = grant[1] ? req1_op : req0_op;

  fpu_rr_grant u_grant (
    .req        ({req1_valid_i, req0_valid_i}),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Outputs are gated by reset so an op caught mid-flight never emits a response.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    done         = 1'b0;
    timeout      = 1'b0;
    active       = !reset_i;
    in_flight    = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req0_ready_o = active && grant[0];
        req1_ready_o = active && grant[1];
        if (|grant) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        in_flight = active;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        in_flight = active;
        if (!fpu_busy_i) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid_o = active && !owner_q;
        rsp1_valid_o = active &&  owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q     <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      data_q   <= '0;
      fflags_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_sel;
        owner_q <= grant[1];
        last_q  <= grant[1];
        cnt_q   <= '0;
      end
      if (done) begin
        data_q   <= fpu_out_i;
        fflags_q <= fpu_fflags_i;
        err_q    <= 1'b0;
      end else if (timeout) begin
        data_q   <= '0;
        fflags_q <= '0;
        err_q    <= 1'b1;
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign fpu_enable_o  = in_flight;
  assign fpu_instr_o   = in_flight ? op_q.instr : NOP_INSTR;
  assign fpu_rs1_o     = in_flight ? op_q.rs1   : '0;
  assign fpu_rs2_o     = in_flight ? op_q.rs2   : '0;
  assign fpu_rs3_o     = in_flight ? op_q.rs3   : '0;
  assign fpu_rm_o      = in_flight ? op_q.rm    : '0;

  assign rsp0_data_o   = rsp0_valid_o ? data_q   : '0;
  assign rsp0_fflags_o = rsp0_valid_o ? fflags_q : '0;
  assign rsp0_err_o    = rsp0_valid_o && err_q;
  assign rsp1_data_o   = rsp1_valid_o ? data_q   : '0;
  assign rsp1_fflags_o = rsp1_valid_o ? fflags_q : '0;
  assign rsp1_err_o    = rsp1_valid_o && err_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter.
module tb_fpu_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_instr_i, req1_instr_i;
  logic [63:0] req0_rs1_i, req0_rs2_i, req0_rs3_i;
  logic [63:0] req1_rs1_i, req1_rs2_i, req1_rs3_i;
  logic [2:0]  req0_rm_i, req1_rm_i;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic [63:0] rsp0_data_o, rsp1_data_o;
  logic [4:0]  rsp0_fflags_o, rsp1_fflags_o;
  logic        rsp0_err_o, rsp1_err_o;
  logic        fpu_enable_o;
  logic [31:0] fpu_instr_o;
  logic [63:0] fpu_rs1_o, fpu_rs2_o, fpu_rs3_o;
  logic [2:0]  fpu_rm_o;
  logic        fpu_busy_i;
  logic [63:0] fpu_out_i;
  logic [4:0]  fpu_fflags_i;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk_i = ~clk_i;

  fpu_arbiter #(.NOP_INSTR(32'h0000_0013), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_instr_i(req0_instr_i),
    .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_rs3_i(req0_rs3_i), .req0_rm_i(req0_rm_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_instr_i(req1_instr_i),
    .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_rs3_i(req1_rs3_i), .req1_rm_i(req1_rm_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_data_o(rsp0_data_o), .rsp0_fflags_o(rsp0_fflags_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_data_o(rsp1_data_o), .rsp1_fflags_o(rsp1_fflags_o), .rsp1_err_o(rsp1_err_o),
    .fpu_enable_o(fpu_enable_o), .fpu_instr_o(fpu_instr_o),
    .fpu_rs1_o(fpu_rs1_o), .fpu_rs2_o(fpu_rs2_o), .fpu_rs3_o(fpu_rs3_o), .fpu_rm_o(fpu_rm_o),
    .fpu_busy_i(fpu_busy_i), .fpu_out_i(fpu_out_i), .fpu_fflags_i(fpu_fflags_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    tick(); tick();
    checks++; if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", req1_ready_o, req0_ready_o); end
    checks++; if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0 || rsp0_err_o !== 1'b0) begin errors++; $display("FAIL reset_rsp: got v%b%b e%b expected 000", rsp1_valid_o, rsp0_valid_o, rsp0_err_o); end
    checks++; if (fpu_enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", fpu_enable_o); end
    checks++; if (fpu_instr_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", fpu_instr_o, NOP); end
    checks++; if (fpu_rs1_o !== 64'h0 || rsp0_data_o !== 64'h0 || rsp0_fflags_o !== 5'h0) begin errors++; $display("FAIL reset_data: got rs1 %h data %h ff %h expected 0", fpu_rs1_o, rsp0_data_o, rsp0_fflags_o); end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; reset_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req0_instr_i = 32'h2a00_1053; req0_rs1_i = 64'h1111; req0_rs2_i = 64'h2222; req0_rs3_i = 64'h3333;
    req0_rm_i = 3'b010; fpu_out_i = 64'h3f80_0000; fpu_fflags_i = 5'h0; fpu_busy_i = 1'b0;
    req0_valid_i = 1'b1; #1;
    checks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin errors++; $display("FAIL single_ready: got %b%b expected 01", req1_ready_o, req0_ready_o); end
    tick(); req0_valid_i = 1'b0;
    checks++; if (fpu_enable_o !== 1'b1 || fpu_instr_o !== 32'h2a00_1053) begin errors++; $display("FAIL single_issue: got en %b instr %h expected 1 2a001053", fpu_enable_o, fpu_instr_o); end
    checks++; if (fpu_rs1_o !== 64'h1111 || fpu_rs2_o !== 64'h2222 || fpu_rs3_o !== 64'h3333 || fpu_rm_o !== 3'b010) begin errors++; $display("FAIL single_operands: got %h %h %h %b", fpu_rs1_o, fpu_rs2_o, fpu_rs3_o, fpu_rm_o); end
    checks++; if (req0_ready_o !== 1'b0 || rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL single_issue_flags: got rdy %b rsp %b expected 0 0", req0_ready_o, rsp0_valid_o); end
    tick();
    checks++; if (fpu_enable_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL single_wait: got en %b rsp %b expected 1 0", fpu_enable_o, rsp0_valid_o); end
    tick();
    checks++; if (rsp0_valid_o !== 1'b1 || rsp0_data_o !== 64'h3f80_0000 || rsp0_err_o !== 1'b0) begin errors++; $display("FAIL single_rsp: got v %b data %h err %b expected 1 3f800000 0", rsp0_valid_o, rsp0_data_o, rsp0_err_o); end
    checks++; if (rsp1_valid_o !== 1'b0 || fpu_enable_o !== 1'b0 || fpu_instr_o !== NOP) begin errors++; $display("FAIL single_resp_side: got rsp1 %b en %b instr %h", rsp1_valid_o, fpu_enable_o, fpu_instr_o); end
    tick();
    checks++; if (rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", rsp0_valid_o); end
  endtask

  task automatic test_round_robin();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    req0_instr_i = 32'hAAAA_0001; req1_instr_i = 32'hBBBB_0002; fpu_busy_i = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1; #1;
    checks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin errors++; $display("FAIL rr_first: got %b%b expected 01", req1_ready_o, req0_ready_o); end
    tick();
    checks++; if (fpu_instr_o !== 32'hAAAA_0001 || req1_ready_o !== 1'b0) begin errors++; $display("FAIL rr_issue0: got instr %h rdy1 %b expected aaaa0001 0", fpu_instr_o, req1_ready_o); end
    tick(); tick();
    checks++; if (rsp0_valid_o !== 1'b1 || rsp1_valid_o !== 1'b0) begin errors++; $display("FAIL rr_rsp0: got %b%b expected 01", rsp1_valid_o, rsp0_valid_o); end
    tick();
    checks++; if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin errors++; $display("FAIL rr_second: got %b%b expected 10", req1_ready_o, req0_ready_o); end
    tick();
    checks++; if (fpu_instr_o !== 32'hBBBB_0002) begin errors++; $display("FAIL rr_issue1: got %h expected bbbb0002", fpu_instr_o); end
    tick(); tick();
    checks++; if (rsp1_valid_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL rr_rsp1: got %b%b expected 10", rsp1_valid_o, rsp0_valid_o); end
    tick();
    checks++; if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin errors++; $display("FAIL rr_alternate: got %b%b expected 01", req1_ready_o, req0_ready_o); end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
  endtask

  task automatic test_busy_wait();
    req0_instr_i = 32'h1234_5653; fpu_out_i = 64'hdead_beef_0000_0001; fpu_busy_i = 1'b0;
    req0_valid_i = 1'b1;
    tick(); req0_valid_i = 1'b0; fpu_busy_i = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++; if (fpu_instr_o !== 32'h1234_5653 || fpu_enable_o !== 1'b1 || rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL busy_hold[%0d]: got instr %h en %b rsp %b", i, fpu_instr_o, fpu_enable_o, rsp0_valid_o); end
    end
    fpu_busy_i = 1'b0;
    tick();
    checks++; if (rsp0_valid_o !== 1'b1 || rsp0_data_o !== 64'hdead_beef_0000_0001) begin errors++; $display("FAIL busy_rsp: got v %b data %h expected 1 deadbeef00000001", rsp0_valid_o, rsp0_data_o); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    req0_instr_i = 32'h0bad_0053; fpu_out_i = 64'h5555_5555; fpu_fflags_i = 5'h1f; fpu_busy_i = 1'b0;
    req0_valid_i = 1'b1;
    tick(); req0_valid_i = 1'b0; fpu_busy_i = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      tick(); n++;
      if (rsp0_valid_o === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || n != 65) begin errors++; $display("FAIL timeout_latency: got seen %b after %0d cycles expected 1 after 65", seen, n); end
    checks++; if (rsp0_err_o !== 1'b1 || rsp0_data_o !== 64'h0 || rsp0_fflags_o !== 5'h0) begin errors++; $display("FAIL timeout_rsp: got err %b data %h ff %h expected 1 0 0", rsp0_err_o, rsp0_data_o, rsp0_fflags_o); end
    tick();
    checks++; if (fpu_instr_o !== NOP || fpu_enable_o !== 1'b0 || rsp0_valid_o !== 1'b0) begin errors++; $display("FAIL timeout_idle: got instr %h en %b rsp %b", fpu_instr_o, fpu_enable_o, rsp0_valid_o); end
    fpu_busy_i = 1'b0; fpu_fflags_i = 5'h0;
  endtask

  task automatic test_reset_mid_op();
    req1_instr_i = 32'hcafe_0053; req1_rs1_i = 64'h77; fpu_busy_i = 1'b0;
    req1_valid_i = 1'b1;
    tick(); req1_valid_i = 1'b0; fpu_busy_i = 1'b1;
    tick(); tick();
    reset_i = 1'b1;
    tick();
    checks++; if (fpu_enable_o !== 1'b0 || fpu_instr_o !== NOP || fpu_rs1_o !== 64'h0 || rsp1_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got en %b instr %h rs1 %h rsp1 %b", fpu_enable_o, fpu_instr_o, fpu_rs1_o, rsp1_valid_o); end
    reset_i = 1'b0; fpu_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_no_pulse[%0d]: got %b%b expected 00", i, rsp1_valid_o, rsp0_valid_o); end
    end
    req0_instr_i = 32'h0000_1153; req0_valid_i = 1'b1; #1;
    checks++; if (req0_ready_o !== 1'b1) begin errors++; $display("FAIL midreset_accept: got %b expected 1", req0_ready_o); end
    tick(); req0_valid_i = 1'b0;
    checks++; if (fpu_instr_o !== 32'h0000_1153) begin errors++; $display("FAIL midreset_issue: got %h expected 00001153", fpu_instr_o); end
    tick(); tick(); tick();
  endtask

  task automatic test_holdoff_fflags();
    req0_instr_i = 32'h0f0f_0053; req1_instr_i = 32'h0e0e_0053;
    fpu_busy_i = 1'b0; fpu_fflags_i = 5'b00001; fpu_out_i = 64'h4000_0000;
    req0_valid_i = 1'b1;
    tick(); req0_valid_i = 1'b0; req1_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req1_ready_o !== 1'b0) begin errors++; $display("FAIL holdoff_ready1[%0d]: got %b expected 0", i, req1_ready_o); end
      if (i < 2) tick();
    end
    checks++; if (rsp0_valid_o !== 1'b1 || rsp0_fflags_o !== 5'b00001) begin errors++; $display("FAIL holdoff_rsp0_fflags: got v %b ff %b expected 1 00001", rsp0_valid_o, rsp0_fflags_o); end
    tick();
    checks++; if (req1_ready_o !== 1'b1) begin errors++; $display("FAIL holdoff_grant1: got %b expected 1", req1_ready_o); end
    tick(); req1_valid_i = 1'b0;
    checks++; if (fpu_instr_o !== 32'h0e0e_0053) begin errors++; $display("FAIL holdoff_issue1: got %h expected 0e0e0053", fpu_instr_o); end
    tick(); tick();
    checks++; if (rsp1_valid_o !== 1'b1 || rsp1_fflags_o !== 5'b00001 || rsp1_err_o !== 1'b0) begin errors++; $display("FAIL holdoff_rsp1: got v %b ff %b err %b expected 1 00001 0", rsp1_valid_o, rsp1_fflags_o, rsp1_err_o); end
    tick();
  endtask

  initial begin
    reset_i = 1'b1; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_instr_i = '0; req0_rs1_i = '0; req0_rs2_i = '0; req0_rs3_i = '0; req0_rm_i = '0;
    req1_instr_i = '0; req1_rs1_i = '0; req1_rs2_i = '0; req1_rs3_i = '0; req1_rm_i = '0;
    fpu_busy_i = 1'b0; fpu_out_i = '0; fpu_fflags_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_wait();
    test_timeout();
    test_reset_mid_op();
    test_holdoff_fflags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, instruction driven to FPU when no op is in flight.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before an op is abandoned.
REQ-003 SHALL have port clk_i, input, 1, the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports reqN_valid_i (N=0,1), input, 1, requester N presents an op.
REQ-006 SHALL have ports reqN_ready_o, output, 1, arbiter accepts requester N this cycle.
REQ-007 SHALL have ports reqN_instr_i, input, 32, FP instruction word.
REQ-008 SHALL have ports reqN_rs1_i / reqN_rs2_i / reqN_rs3_i, input, 64 each, operands.
REQ-009 SHALL have ports reqN_rm_i, input, 3, rounding mode.
REQ-010 SHALL have ports rspN_valid_o, output, 1, one-cycle result pulse to requester N.
REQ-011 SHALL have ports rspN_data_o, output, 64; rspN_fflags_o, output, 5; rspN_err_o, output, 1 (timeout).
REQ-012 SHALL have FPU-side ports fpu_enable_o 1, fpu_instr_o 32, fpu_rs1_o/rs2_o/rs3_o 64, fpu_rm_o 3 (outputs); fpu_busy_i 1, fpu_out_i 64, fpu_fflags_i 5 (inputs).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: reqN_ready_o high only for the granted requester; all other times both ready low.
REQ-015 Grant SHALL be round-robin: single valid wins; both valid -> requester not granted last time.
REQ-016 Handshake valid&&ready at edge T SHALL latch instr/rs1-3/rm and owner ID; IDLE->ISSUE.
REQ-017 ISSUE (cycle T+1): fpu_instr_o = latched instr, operands/rm driven; fpu_busy_i ignored; ->WAIT.
REQ-018 WAIT: instr and operands held; first cycle with fpu_busy_i=0 SHALL capture fpu_out_i, fpu_fflags_i; ->RESP.
REQ-019 WAIT counter SHALL increment per busy cycle; reaching TIMEOUT_CYCLES -> RESP with err=1, data=0, fflags=0.
REQ-020 RESP: rspN_valid_o high exactly one cycle for owner only, data/fflags/err valid same cycle; ->IDLE.
REQ-021 Minimum latency: accept T, result pulse T+3 (FPU busy never raised); throughput max one op per 4 cycles.
REQ-022 fpu_enable_o high in ISSUE and WAIT only; fpu_instr_o = NOP_INSTR in IDLE and RESP.
REQ-023 No response backpressure; requester SHALL not be re-granted before its RESP completes.
REQ-024 Requests arriving outside IDLE SHALL be held off (ready low), never dropped or reordered within a requester.

Reset
REQ-025 reset_i SHALL force IDLE, last-grant = requester 1 (so requester 0 wins first tie), counter 0.
REQ-026 During/after reset: all ready/rsp valid/err low, data/fflags 0, fpu_enable_o 0, fpu_instr_o NOP_INSTR, operands 0.
REQ-027 Reset mid-op SHALL abandon the op silently; no response pulse issued.

Structure
REQ-028 State encoding, NOP_INSTR default, FFLAGS_W=5 and XLEN=64 SHALL live in shared package fpu_pkg.
REQ-029 Round-robin grant logic SHALL be sub-module fpu_rr_grant (2 requests, last-grant input, one-hot grant out).

Verification
REQ-030 Single op req0, instr 32'h2a001053, FPU busy never high, fpu_out_i 64'h3f800000 -> rsp0 pulse at T+3, data 64'h3f800000, err 0.
REQ-031 Both valid from reset -> req0 served first, then req1; next simultaneous pair -> req0 again (alternation).
REQ-032 FPU busy high 10 cycles after ISSUE -> rsp at T+13, fpu_instr_o held stable throughout WAIT.
REQ-033 Busy stuck high, TIMEOUT_CYCLES=64 -> rsp valid with err=1, data 0, then IDLE, fpu_instr_o = 32'h00000013.
REQ-034 reset_i asserted in WAIT -> no rsp pulse, outputs at reset values next cycle, new request accepted after release.
REQ-035 req1 valid held during req0 op -> req1 ready low until IDLE, then accepted; fflags 5'b00001 passed through unchanged.
